// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit add/subtract computed DIGIT bits per clock.
// A registered carry flop ripples between slices, so the combinational path
// is only a DIGIT-bit adder plus the slice select/insert muxing.
module nibble_serial_adder #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rstN,
   input  logic             start,
   input  logic             subtract,
   input  logic [WIDTH-1:0] operandX,
   input  logic [WIDTH-1:0] operandY,
   input  logic             carryIn,
   output logic             ready,
   output logic             valid,
   output logic [WIDTH-1:0] sum,
   output logic             carryOut,
   output logic             overflow,
   output logic             zero
);

   localparam int NSTEP = WIDTH / DIGIT;
   localparam int KW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
   localparam logic [KW-1:0]    K_LAST     = KW'(NSTEP - 1);
   localparam logic [WIDTH-1:0] SLICE_MASK = {WIDTH{1'b1}} >> (WIDTH - DIGIT);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state;
   logic [WIDTH-1:0] opX;
   logic [WIDTH-1:0] opY;     // already inverted for subtract
   logic             carry;   // carry into the current slice
   logic [KW-1:0]    k;       // slice index, never exceeds NSTEP-1

   int               shamt;
   logic [DIGIT-1:0] xs;
   logic [DIGIT-1:0] ys;
   logic [DIGIT:0]   slice;   // top bit is the slice carry-out
   logic             msb_cin;
   logic [WIDTH-1:0] next_sum;

   // Current slice add and the sum with that slice merged in.
   always_comb begin
      shamt    = DIGIT * int'(k);
      xs       = DIGIT'(opX >> shamt);
      ys       = DIGIT'(opY >> shamt);
      slice    = {1'b0, xs} + {1'b0, ys} + {{DIGIT{1'b0}}, carry};
      // carry into the slice MSB recovered from the MSB sum bit; on the last
      // slice this is the carry into bit WIDTH-1
      msb_cin  = slice[DIGIT-1] ^ xs[DIGIT-1] ^ ys[DIGIT-1];
      next_sum = (sum & ~(SLICE_MASK << shamt)) |
                 (WIDTH'(slice[DIGIT-1:0]) << shamt);
   end

   // Control FSM, operand/carry registers and registered result/flags.
   always_ff @(posedge clk) begin
      if (!rstN) begin
         state    <= IDLE;
         opX      <= '0;
         opY      <= '0;
         carry    <= 1'b0;
         k        <= '0;
         ready    <= 1'b1;
         valid    <= 1'b0;
         sum      <= '0;
         carryOut <= 1'b0;
         overflow <= 1'b0;
         zero     <= 1'b0;
      end else begin
         valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  opX   <= operandX;
                  opY   <= subtract ? ~operandY : operandY;
                  carry <= subtract ? 1'b1 : carryIn;
                  k     <= '0;
                  ready <= 1'b0;
                  state <= RUN;
               end
            end
            RUN: begin
               sum   <= next_sum;
               carry <= slice[DIGIT];
               if (k == K_LAST) begin
                  carryOut <= slice[DIGIT];
                  overflow <= msb_cin ^ slice[DIGIT];
                  zero     <= (next_sum == '0);
                  valid    <= 1'b1;
                  ready    <= 1'b1;
                  k        <= '0;
                  state    <= IDLE;
               end else begin
                  k <= k + KW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder (WIDTH=16, DIGIT=4).
module tb_nibble_serial_adder;

   localparam int W = 16;
   localparam int NSTEP = 4;

   logic         clk = 1'b0;
   logic         rstN = 1'b0;
   logic         start = 1'b0;
   logic         subtract = 1'b0;
   logic [W-1:0] operandX = '0;
   logic [W-1:0] operandY = '0;
   logic         carryIn = 1'b0;
   logic         ready, valid, carryOut, overflow, zero;
   logic [W-1:0] sum;

   int n_chk = 0;
   int n_fail = 0;

   nibble_serial_adder #(.WIDTH(W), .DIGIT(4)) dut (
      .clk(clk), .rstN(rstN), .start(start), .subtract(subtract),
      .operandX(operandX), .operandY(operandY), .carryIn(carryIn),
      .ready(ready), .valid(valid), .sum(sum), .carryOut(carryOut),
      .overflow(overflow), .zero(zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      string        name;
      logic         sub;
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic         cin;
      logic [W-1:0] s;
      logic         c;
      logic         ov;
      logic         z;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Drive start at a falling edge, return just after the accepting edge.
   task automatic accept(input logic sub, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic cin);
      @(negedge clk);
      chk("ready_before_start", 32'(ready), 32'd1);
      start = 1'b1; subtract = sub; operandX = x; operandY = y; carryIn = cin;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Wait (bounded) for valid; cyc is edges since accept, ready must stay low before it.
   task automatic wait_valid(input int done, output int cyc);
      bit ready_bad = 1'b0;
      cyc = done;
      while (1) begin
         if (cyc >= 10) break;
         @(posedge clk); #1;
         cyc++;
         if (valid) break;
         if (ready) ready_bad = 1'b1;
      end
      chk("ready_low_during_run", 32'(ready_bad), 32'd0);
      chk("valid_latency", 32'(cyc), 32'(NSTEP));
   endtask

   task automatic chk_result(input string name, input logic [W-1:0] s, input logic c,
                             input logic ov, input logic z);
      chk({name, "_sum"}, 32'(sum), 32'(s));
      chk({name, "_carry"}, 32'(carryOut), 32'(c));
      chk({name, "_ovf"}, 32'(overflow), 32'(ov));
      chk({name, "_zero"}, 32'(zero), 32'(z));
   endtask

   initial begin
      int cyc;
      bit seen;

      vecs[0] = '{"add_nowrap", 1'b0, 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{"wrap_zero",  1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
      vecs[2] = '{"wrap_cin",   1'b0, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
      vecs[3] = '{"add_ovf",    1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
      vecs[4] = '{"sub_ovf",    1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0};
      vecs[5] = '{"sub_borrow", 1'b1, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{"sub_equal",  1'b1, 16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
      vecs[7] = '{"add_negneg", 1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_valid", 32'(valid), 32'd0);
      chk_result("rst", 16'h0000, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rstN = 1'b1;

      // table-driven operations
      foreach (vecs[i]) begin
         accept(vecs[i].sub, vecs[i].x, vecs[i].y, vecs[i].cin);
         wait_valid(0, cyc);
         chk_result(vecs[i].name, vecs[i].s, vecs[i].c, vecs[i].ov, vecs[i].z);
         @(posedge clk); #1;
         chk({vecs[i].name, "_valid_pulse"}, 32'(valid), 32'd0);
      end

      // start during RUN is ignored
      accept(1'b0, 16'h0100, 16'h0020, 1'b0);
      @(negedge clk);
      start = 1'b1; subtract = 1'b1; operandX = 16'hAAAA; operandY = 16'h5555;
      @(posedge clk); #1;
      start = 1'b0;
      wait_valid(1, cyc);
      chk_result("ignore_start", 16'h0120, 1'b0, 1'b0, 1'b0);

      // back-to-back: start in the valid cycle
      accept(1'b0, 16'h0003, 16'h0004, 1'b0);
      wait_valid(0, cyc);
      chk_result("b2b_first", 16'h0007, 1'b0, 1'b0, 1'b0);
      accept(1'b1, 16'h0010, 16'h0001, 1'b0);
      chk("b2b_sum_hold_at_accept", 32'(sum), 32'h0007);
      seen = 1'b0;
      cyc = 0;
      while (cyc < 10) begin
         @(posedge clk); #1;
         cyc++;
         if (valid) break;
         if (carryOut) seen = 1'b1;
      end
      chk("b2b_flags_hold", 32'(seen), 32'd0);
      chk("b2b_latency", 32'(cyc), 32'(NSTEP));
      chk_result("b2b_second", 16'h000F, 1'b1, 1'b0, 1'b0);

      // reset on the 2nd RUN cycle aborts the operation
      accept(1'b0, 16'h0123, 16'h0111, 1'b0);
      @(posedge clk); #1;
      chk("abort_partial_sum", 32'(sum), 32'h0004);
      @(negedge clk);
      rstN = 1'b0;
      @(posedge clk); #1;
      chk("abort_ready", 32'(ready), 32'd1);
      chk_result("abort", 16'h0000, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rstN = 1'b1;
      seen = 1'b0;
      repeat (8) begin
         @(posedge clk); #1;
         if (valid) seen = 1'b1;
      end
      chk("abort_no_valid", 32'(seen), 32'd0);
      chk("abort_idle_ready", 32'(ready), 32'd1);

      // still functional after the abort
      accept(1'b0, 16'h00F0, 16'h0010, 1'b0);
      wait_valid(0, cyc);
      chk_result("post_abort", 16'h0100, 1'b0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
